// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Constants shared by the fetch stage and the decoder: opcode
//                values, fetch state encodings, default ROM geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Default ROM address width and retired-counter width
    localparam int ROM_ADDR_W     = 8;
    localparam int RETIRED_CNT_W  = 16;

    // Opcodes the fetch stage needs to know about
    localparam logic [7:0]  NOP      = 8'h00;
    localparam logic [7:0]  HLT      = 8'hFF;
    localparam logic [23:0] NOP_WORD = {NOP, 16'h0000};

    // Fetch state encodings
    localparam logic [1:0]  FS_BOOT  = 2'd0;
    localparam logic [1:0]  FS_RUN   = 2'd1;
    localparam logic [1:0]  FS_HALT  = 2'd2;

    // True when the ROM word carries the HLT opcode
    function automatic logic is_hlt(input logic [23:0] word);
        return (word[23:16] == HLT);
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the fetch PC (address of the
//                word currently returned by the synchronous ROM), drives the
//                next ROM address, masks non-executable cycles to NOP, and
//                handles stall, jump redirect, HLT/resume and a retired count.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int CNT_W  = RETIRED_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data_in,
    output logic [23:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              resume,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  retired_q,  retired_d;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_rom_addr;
    logic              w_valid;
    logic              w_hlt_seen;

    // Sequential wrap of the PC is natural modulo arithmetic at ADDR_W bits
    assign w_pc_inc   = fetch_pc_q + ADDR_W'(1);
    assign w_hlt_seen = is_hlt(rom_data_in);

    // Next-state / next-PC selection; the address requested this cycle always
    // becomes the fetch PC, so fetch_pc tracks the word on rom_data_in
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        w_rom_addr = fetch_pc_q;
        w_valid    = 1'b0;
        case (state_q)
            FS_BOOT: begin
                w_rom_addr = '0;
                fetch_pc_d = '0;
                state_d    = FS_RUN;
            end
            FS_RUN: begin
                if (stall) begin
                    // Re-read the same word so it reappears once stall drops
                    w_rom_addr = fetch_pc_q;
                end else if (w_hlt_seen) begin
                    // HLT beats a concurrent jump; the HLT word is not retired
                    w_rom_addr = fetch_pc_q;
                    state_d    = FS_HALT;
                end else if (jump_en) begin
                    // Jump-carrying word executes; target arrives next cycle
                    w_valid    = 1'b1;
                    w_rom_addr = jump_addr;
                    fetch_pc_d = jump_addr;
                end else begin
                    w_valid    = 1'b1;
                    w_rom_addr = w_pc_inc;
                    fetch_pc_d = w_pc_inc;
                end
            end
            FS_HALT: begin
                // fetch_pc keeps pointing at the HLT word until resumed
                if (resume) begin
                    w_rom_addr = w_pc_inc;
                    fetch_pc_d = w_pc_inc;
                    state_d    = FS_RUN;
                end
            end
            default: begin
                w_rom_addr = '0;
                fetch_pc_d = '0;
                state_d    = FS_BOOT;
            end
        endcase
    end

    // Retired counter: every executed instruction (only RUN can assert valid)
    always_comb begin
        retired_d = retired_q;
        if (w_valid) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State, fetch PC and counter registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_BOOT;
            fetch_pc_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            retired_q  <= retired_d;
        end
    end

    assign rom_addr    = w_rom_addr;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? rom_data_in : NOP_WORD;
    assign pc          = fetch_pc_q;
    assign halted      = (state_q == FS_HALT);
    assign retired     = retired_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A synchronous ROM array
//                feeds the DUT; a word-level reference model predicts which
//                word is fetched, whether it executes, and the retired count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data_in;
    logic [23:0] instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        stall;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic        resume;
    logic        halted;
    logic [15:0] retired;

    logic [23:0] rom [0:255];

    int errors = 0;
    int checks = 0;

    // Reference model state: word address on the ROM output, mode, count
    int m_pc;
    bit m_boot;
    bit m_halt;
    int m_ret;

    fetch_unit #(.ADDR_W(8), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data_in (rom_data_in),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .resume      (resume),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for last cycle's address
    always @(posedge clk) rom_data_in <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Random word that is never HLT
    function automatic logic [23:0] rand_word();
        logic [23:0] w;
        w = 24'($urandom);
        if (w[23:16] == 8'hFF) w[23:16] = 8'hFE;
        return w;
    endfunction

    // One clock cycle: apply inputs at negedge, check outputs, advance model
    task automatic step(input bit s, input bit j, input int ja, input bit r);
        logic [23:0] w;
        int  nxt;
        bit  v;
        bit  go_halt;
        bit  go_run;
        stall     = s;
        jump_en   = j;
        jump_addr = ja[7:0];
        resume    = r;
        #1;
        w       = rom[m_pc];
        v       = 1'b0;
        nxt     = m_pc;
        go_halt = 1'b0;
        go_run  = 1'b0;
        if (m_boot) begin
            nxt = 0;
        end else if (m_halt) begin
            if (r) begin
                nxt    = (m_pc + 1) % 256;
                go_run = 1'b1;
            end
        end else if (s) begin
            nxt = m_pc;
        end else if (w[23:16] == 8'hFF) begin
            go_halt = 1'b1;
        end else if (j) begin
            v   = 1'b1;
            nxt = ja % 256;
        end else begin
            v   = 1'b1;
            nxt = (m_pc + 1) % 256;
        end
        chk("rom_addr",    32'(rom_addr),    32'(nxt));
        chk("instr_valid", 32'(instr_valid), 32'(v));
        chk("instr",       32'(instr),       v ? 32'(w) : 32'h0);
        chk("pc",          32'(pc),          32'(m_pc));
        chk("halted",      32'(halted),      32'(m_halt));
        chk("retired",     32'(retired),     32'(m_ret % 65536));
        @(posedge clk);
        m_boot = 1'b0;
        m_pc   = nxt;
        if (go_halt) m_halt = 1'b1;
        if (go_run)  m_halt = 1'b0;
        if (v)       m_ret++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_ret  = 0;
    endtask

    task automatic do_reset();
        stall = 0; jump_en = 0; jump_addr = 0; resume = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; jump_en = 0; jump_addr = 0; resume = 0;
        for (int i = 0; i < 256; i++) rom[i] = rand_word();
        rom[0] = 24'h010105;   // LDR r1,5
        rom[1] = 24'h010203;   // LDR r2,3
        rom[2] = 24'h020102;   // ADD r1,r2
        rom[3] = 24'h000000;   // NOP
        rom[6] = 24'hFF0000;   // HLT
        @(negedge clk);

        // Reset values while rst_n is low
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_valid",    32'(instr_valid), 32'h0);
        chk("rst_instr",    32'(instr), 32'h0);
        chk("rst_halted",   32'(halted), 32'h0);
        chk("rst_retired",  32'(retired), 32'h0);
        @(negedge clk);

        // Boot then four sequential words
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("retired_after4", 32'(retired), 32'd4);

        // Stall while pc=2
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("stall_pc", 32'(pc), 32'd2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Jump while stalled is ignored, then taken jump to 0x40
        step(1, 1, 8'h40, 0);
        chk("stall_jump_pc", 32'(pc), 32'd5);
        step(0, 1, 8'h40, 0);
        chk("jump_pc", 32'(pc), 32'h40);
        chk("jump_instr", 32'(instr), 32'(rom[8'h40]));

        // Jump into the HLT word, sit halted, then resume
        step(0, 1, 6, 0);
        step(0, 1, 8'h10, 0);     // HLT wins over the jump
        for (int i = 0; i < 10; i++) step(i[0], i[1], 8'h33, 0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc",   32'(pc), 32'd6);
        step(0, 0, 0, 1);
        chk("resume_pc", 32'(pc), 32'd7);
        step(0, 0, 0, 0);

        // PC wrap through 0xFF
        step(0, 1, 8'hFD, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("wrap_pc", 32'(pc), 32'd2);

        // Asynchronous reset mid-run at pc=0x23
        step(0, 1, 8'h23, 0);
        chk("pre_async_pc", 32'(pc), 32'h23);
        stall = 0; jump_en = 0; resume = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rom_addr", 32'(rom_addr), 32'h0);
        chk("async_pc",       32'(pc), 32'h0);
        chk("async_valid",    32'(instr_valid), 32'h0);
        chk("async_instr",    32'(instr), 32'h0);
        chk("async_halted",   32'(halted), 32'h0);
        chk("async_retired",  32'(retired), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomized run against a fresh ROM with scattered HLT words
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = rand_word();
            if ($urandom_range(0, 15) == 0) rom[i][23:16] = 8'hFF;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 255)),
                 $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decoder. Drives the ROM address and holds the program counter. Receives the 24-bit ROM word one cycle later and presents it to the decoder as {opcode, arg_a, arg_b}, or a forced NOP when there is no valid instruction. Handles stall, jump redirect, HLT detection with resume, and a retired-instruction counter.

Parameters:
ADDR_W, 8, ROM address width; PC wraps modulo 2^ADDR_W
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  ADDR_W  ROM read address (combinational); synchronous ROM returns data next cycle
rom_data_in  in  24  ROM read data for the address presented last cycle
instr  out  24  word to the decoder; 24'h000000 (NOP) whenever instr_valid=0
instr_valid  out  1  instr is a real instruction the decoder may execute this cycle
pc  out  ADDR_W  address of the word currently on rom_data_in (fetch_pc)
stall  in  1  downstream freeze request
jump_en  in  1  redirect request from execute; qualified below
jump_addr  in  ADDR_W  redirect target
resume  in  1  single-cycle pulse; leaves HALT
halted  out  1  high while in HALT
retired  out  CNT_W  count of executed instructions, wraps

Behaviour:
- States: BOOT, RUN, HALT. The reset state is BOOT. Async reset forces BOOT, fetch_pc=0, retired=0 at any time, including mid-run.
- Reset outputs: rom_addr=0, instr=0, instr_valid=0, pc=0, halted=0, retired=0.
- BOOT lasts exactly 1 cycle after rst_n deasserts.
  - rom_addr=0, instr_valid=0.
  - Next state is RUN with fetch_pc=0.
- hlt_seen = (rom_data_in[23:16]==HLT).
- RUN, per cycle, in priority order:
  1. stall=1: rom_addr=fetch_pc (re-read the same word), instr_valid=0, fetch_pc held. jump_en is ignored. The word reappears the cycle after stall drops.
  2. hlt_seen: instr_valid=0, rom_addr=fetch_pc, next state HALT. HLT is not counted as retired.
  3. jump_en=1: instr_valid=1 (the jump-carrying instruction executes), rom_addr=jump_addr, fetch_pc<=jump_addr.
  4. Otherwise: instr_valid=1, rom_addr=fetch_pc+1 (mod 2^ADDR_W), fetch_pc<=fetch_pc+1.
- instr = instr_valid ? rom_data_in : 24'h000000.
- Jump latency: the target word is on instr the cycle after jump_en is accepted. There is no bubble.
- retired increments (wraps at 2^CNT_W) on every cycle with state RUN and instr_valid=1.
- HALT:
  - halted=1, instr_valid=0, rom_addr=fetch_pc. fetch_pc still points at the HLT word.
  - resume=1: rom_addr=fetch_pc+1, fetch_pc<=fetch_pc+1, next state RUN.
  - stall, jump_en, and hlt_seen are ignored in HALT.
- resume is ignored outside HALT.
- PC wrap: fetch_pc=2^ADDR_W-1 followed by an increment gives 0. No error flag.
- jump_en together with hlt_seen: HLT wins, and the jump is dropped.

Decomposition:
- global_params.vh gains the following; the decoder and fetch_unit share opcode constants from there:
  - NOP=8'h00
  - HLT=8'hFF
  - fetch state encodings FS_BOOT, FS_RUN, FS_HALT
  - default ROM_ADDR_W
- No sub-module. The next-PC mux, the FSM, and the counter are a single small module.

Test Plan:
- Reset release, ROM[0..3] = LDR r1,5 / LDR r2,3 / ADD r1,r2 / NOP -> cycle 0 (BOOT) instr_valid=0, rom_addr=0; cycles 1..4 present words 0..3 with pc=0..3, instr_valid=1; retired=4 after cycle 4.
- stall high for 3 cycles while pc=2 -> instr=0, instr_valid=0, rom_addr=2, retired frozen; cycle after release: instr=ROM[2], pc=2.
- jump_en=1, jump_addr=8'h40 while pc=5 -> word 5 executes (retired+1); next cycle pc=8'h40, instr=ROM[0x40]. Repeat with stall=1 on the same cycle -> jump ignored, pc stays 5.
- ROM[6]=24'hFF0000 -> at pc=6: instr_valid=0, halted=1 the next cycle, pc=6 held for 10 cycles, retired unchanged; resume pulse -> next cycle pc=7, RUN, instr=ROM[7].
- Run through pc=8'hFF with no jump -> the next pc is 8'h00 and the counter continues.
- Assert rst_n=0 asynchronously mid-run at pc=0x23 -> outputs go to reset values immediately, without waiting for a clk edge; after release, BOOT then pc=0.
